// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue
//   Instruction-byte prefetch queue between the I-cache and the decoder.
//   32 bytes of storage are organised as two 16-byte slots filled a whole
//   line at a time. The decoder sees a 16-byte window starting at a
//   byte-granular read pointer and retires 1..15 bytes per accepted consume.
//   A flush redirects the stream: the queue empties and the first line
//   that arrives afterwards is treated as the target line. Reading of that
//   line starts at the byte offset given with the flush.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   fill_valid      I-cache line available
//   fill_data       16-byte line, [127:120] is the lowest-address byte
//   fill_ready      queue can accept a line this cycle (count <= 16)
//   flush           redirect: discard all bytes
//   flush_eip       new instruction pointer
//   flush_cs        new code segment
//   flush_offset    byte offset of the target within the next fill line
//   consume         decoder accepted the current instruction
//   consume_len     length of that instruction, 1..15
//   IR              16-byte window at the read pointer, [127:120] first byte
//   ir_valid        IR holds 16 valid bytes (count >= 16)
//   EIP             address of the instruction at IR[127:120]
//   CS              current code segment
//   count           number of valid bytes, 0..32
module ir_fetch_queue (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_valid,
  input  logic [127:0] fill_data,
  output logic         fill_ready,
  input  logic         flush,
  input  logic [31:0]  flush_eip,
  input  logic [15:0]  flush_cs,
  input  logic [3:0]   flush_offset,
  input  logic         consume,
  input  logic [3:0]   consume_len,
  output logic [127:0] IR,
  output logic         ir_valid,
  output logic [31:0]  EIP,
  output logic [15:0]  CS,
  output logic [5:0]   count
);

  logic [7:0] mem [32];
  logic [4:0] rd_ptr;
  logic       wr_slot;
  logic [3:0] skip;

  logic       fill_acc;
  logic       cons_acc;
  logic [5:0] fill_add;
  logic [5:0] cons_sub;
  logic [5:0] count_nxt;

  // Both flags come from registered count only, so there is no path from
  // any input to these outputs.
  assign fill_ready = (count <= 6'd16);
  assign ir_valid   = (count >= 6'd16);

  assign fill_acc = fill_valid & fill_ready & ~flush;
  assign cons_acc = consume & ir_valid & ~flush & (consume_len != 4'd0);

  // A line contributes only the bytes at and after the pending skip offset.
  // count + fill_add never exceeds 32 because fills need count <= 16.
  assign fill_add  = fill_acc ? (6'd16 - {2'b00, skip}) : 6'd0;
  assign cons_sub  = cons_acc ? {2'b00, consume_len} : 6'd0;
  assign count_nxt = count + fill_add - cons_sub;

  // State update: reset beats flush, and flush beats fill and consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_slot <= 1'b0;
      skip    <= '0;
      EIP     <= '0;
      CS      <= '0;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_slot <= 1'b0;
      skip    <= flush_offset;
      EIP     <= flush_eip;
      CS      <= flush_cs;
    end else begin
      count <= count_nxt;
      if (fill_acc) begin
        for (int i = 0; i < 16; i++) begin
          mem[{wr_slot, 4'(i)}] <= fill_data[8*(15-i) +: 8];
        end
        wr_slot <= ~wr_slot;
        if (skip != 4'd0) begin
          skip <= '0;
        end
      end
      // A nonzero skip only exists while the queue is empty, so a consume
      // can never coincide with the pointer load for the target line.
      if (fill_acc && (skip != 4'd0)) begin
        rd_ptr <= {wr_slot, skip};
      end else if (cons_acc) begin
        rd_ptr <= rd_ptr + {1'b0, consume_len};
      end
      if (cons_acc) begin
        EIP <= EIP + {28'd0, consume_len};
      end
    end
  end

  // Read window: 16 bytes starting at rd_ptr, wrapping modulo 32.
  always_comb begin
    logic [4:0] idx;
    IR  = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      idx = rd_ptr + 5'(i);
      IR[8*(15-i) +: 8] = mem[idx];
    end
  end

endmodule
